// File: rtl/exu_oitf.sv
`default_nettype none
// ============================================================================
// Module   : exu_oitf
// Purpose  : Outstanding Instruction Track FIFO. Tags long-pipe instructions,
//            flags RAW/WAW hazards for dispatch, retires entries in order.
//            Optional macro OITF_RET_BYPASS_EN: retiring entry is masked from
//            hazard matching and a full FIFO accepts an allocation on retire.
// Revision : 1.0 - initial release
// ============================================================================
module exu_oitf #(
    parameter int OITF_DEPTH = 2,
    parameter int ITAG_W     = 1,
    parameter int RFIDX_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_oitf_ena,
    output logic               disp_oitf_ready,
    output logic [ITAG_W-1:0]  disp_oitf_ptr,
    input  logic               disp_oitf_rs1en,
    input  logic               disp_oitf_rs2en,
    input  logic               disp_oitf_rdwen,
    input  logic [RFIDX_W-1:0] disp_oitf_rs1idx,
    input  logic [RFIDX_W-1:0] disp_oitf_rs2idx,
    input  logic [RFIDX_W-1:0] disp_oitf_rdidx,
    output logic               oitfrd_match_disprs1,
    output logic               oitfrd_match_disprs2,
    output logic               oitfrd_match_disprd,
    input  logic               oitf_ret_ena,
    output logic [ITAG_W-1:0]  oitf_ret_ptr,
    output logic [RFIDX_W-1:0] oitf_ret_rdidx,
    output logic               oitf_ret_rdwen,
    output logic               oitf_empty,
    output logic               oitf_full
);

    localparam logic [ITAG_W-1:0] c_ptr_last = ITAG_W'(OITF_DEPTH - 1);
    localparam logic [ITAG_W-1:0] c_ptr_one  = ITAG_W'(1);

    logic [ITAG_W-1:0]  r_alc_ptr;
    logic [ITAG_W-1:0]  r_ret_ptr;
    logic               r_alc_flg;
    logic               r_ret_flg;
    logic [OITF_DEPTH-1:0] r_vld;
    logic [OITF_DEPTH-1:0] r_rdwen;
    logic [RFIDX_W-1:0] r_rdidx [OITF_DEPTH];

    logic w_ptr_eq;
    logic w_empty;
    logic w_full;
    logic w_alc_fire;
    logic w_ret_fire;
    logic [OITF_DEPTH-1:0] w_hit_rs1;
    logic [OITF_DEPTH-1:0] w_hit_rs2;
    logic [OITF_DEPTH-1:0] w_hit_rd;

    assign w_ptr_eq = (r_alc_ptr == r_ret_ptr);
    assign w_empty  = w_ptr_eq & (r_alc_flg == r_ret_flg);
    assign w_full   = w_ptr_eq & (r_alc_flg != r_ret_flg);

`ifdef OITF_RET_BYPASS_EN
    assign disp_oitf_ready = ~w_full | oitf_ret_ena;
`else
    assign disp_oitf_ready = ~w_full;
`endif

    assign w_alc_fire = disp_oitf_ena & disp_oitf_ready;
    assign w_ret_fire = oitf_ret_ena & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alc_ptr <= '0;
            r_alc_flg <= 1'b0;
            r_ret_ptr <= '0;
            r_ret_flg <= 1'b0;
        end else begin
            if (w_alc_fire) begin
                r_alc_ptr <= (r_alc_ptr == c_ptr_last) ? '0 : r_alc_ptr + c_ptr_one;
                r_alc_flg <= r_alc_flg ^ (r_alc_ptr == c_ptr_last);
            end
            if (w_ret_fire) begin
                r_ret_ptr <= (r_ret_ptr == c_ptr_last) ? '0 : r_ret_ptr + c_ptr_one;
                r_ret_flg <= r_ret_flg ^ (r_ret_ptr == c_ptr_last);
            end
        end
    end

    // When full with bypass, both pointers name the same slot: allocation wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_rdwen <= '0;
            for (int i = 0; i < OITF_DEPTH; i++) begin
                r_rdidx[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (w_ret_fire && (r_ret_ptr == ITAG_W'(i))) begin
                    r_vld[i] <= 1'b0;
                end
                if (w_alc_fire && (r_alc_ptr == ITAG_W'(i))) begin
                    r_vld[i]   <= 1'b1;
                    r_rdwen[i] <= disp_oitf_rdwen;
                    r_rdidx[i] <= disp_oitf_rdidx;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < OITF_DEPTH; g++) begin : g_ent
            logic w_act;
`ifdef OITF_RET_BYPASS_EN
            assign w_act = r_vld[g] & ~(w_ret_fire & (r_ret_ptr == ITAG_W'(g)));
`else
            assign w_act = r_vld[g];
`endif
            assign w_hit_rs1[g] = w_act & r_rdwen[g] & (r_rdidx[g] == disp_oitf_rs1idx);
            assign w_hit_rs2[g] = w_act & r_rdwen[g] & (r_rdidx[g] == disp_oitf_rs2idx);
            assign w_hit_rd[g]  = w_act & r_rdwen[g] & (r_rdidx[g] == disp_oitf_rdidx);
        end
    endgenerate

    assign oitfrd_match_disprs1 = disp_oitf_rs1en & (|disp_oitf_rs1idx) & (|w_hit_rs1);
    assign oitfrd_match_disprs2 = disp_oitf_rs2en & (|disp_oitf_rs2idx) & (|w_hit_rs2);
    assign oitfrd_match_disprd  = disp_oitf_rdwen & (|disp_oitf_rdidx)  & (|w_hit_rd);

    assign disp_oitf_ptr  = r_alc_ptr;
    assign oitf_ret_ptr   = r_ret_ptr;
    assign oitf_ret_rdidx = r_rdidx[r_ret_ptr];
    assign oitf_ret_rdwen = r_rdwen[r_ret_ptr];
    assign oitf_empty     = w_empty;
    assign oitf_full      = w_full;

endmodule
`default_nettype wire

// File: doc/exu_oitf.md
Name: exu_oitf

Overview:
- Outstanding Instruction Track FIFO for the EXU.
- Records every long-pipe instruction (load/store, mul/div) accepted by dispatch and tags it with an ITAG.
- Checks each newly dispatching instruction for RAW/WAW hazards against all in-flight entries and reports the result to dispatch.
- Releases entries in program order when the long-pipe writeback retires them. Sits between exu_disp and the long-pipe writeback arbiter.

Parameters:
- OITF_DEPTH, 2, number of entries; any value >= 2.
- ITAG_W, 1, ITAG/pointer width; must equal clog2(OITF_DEPTH).
- RFIDX_W, 5, register-file index width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- disp_oitf_ena  input  1  allocate one entry this cycle (dispatch handshake fired on a long-pipe instruction)
- disp_oitf_ready  output  1  an entry is free
- disp_oitf_ptr  output  ITAG_W  ITAG the next allocation will receive
- disp_oitf_rs1en  input  1  dispatching instruction reads rs1
- disp_oitf_rs2en  input  1  dispatching instruction reads rs2
- disp_oitf_rdwen  input  1  dispatching instruction writes rd
- disp_oitf_rs1idx  input  RFIDX_W  rs1 index
- disp_oitf_rs2idx  input  RFIDX_W  rs2 index
- disp_oitf_rdidx  input  RFIDX_W  rd index
- oitfrd_match_disprs1  output  1  rs1 RAW hazard with a valid entry
- oitfrd_match_disprs2  output  1  rs2 RAW hazard with a valid entry
- oitfrd_match_disprd  output  1  rd WAW hazard with a valid entry
- oitf_ret_ena  input  1  retire the oldest entry this cycle
- oitf_ret_ptr  output  ITAG_W  ITAG of the oldest entry
- oitf_ret_rdidx  output  RFIDX_W  rd index of the oldest entry
- oitf_ret_rdwen  output  1  rdwen of the oldest entry
- oitf_empty  output  1  no valid entries
- oitf_full  output  1  all entries valid

Behaviour:
- Storage: per entry a valid bit, rdwen and rdidx. Pointers: alc_ptr and ret_ptr, each with a wrap flag.
- Wrap-around: a pointer at OITF_DEPTH-1 advances to 0 and toggles its wrap flag. Required for non-power-of-2 depths.
- empty = (alc_ptr == ret_ptr) && (flags equal).
- full = (alc_ptr == ret_ptr) && (flags differ).
- disp_oitf_ready = ~oitf_full. disp_oitf_ptr = alc_ptr.
- Allocate: disp_oitf_ena && ~full.
  - Writes vld=1, rdwen and rdidx at alc_ptr on the clock edge.
  - Advances alc_ptr.
  - disp_oitf_ena while full is ignored; no state change.
- Retire: oitf_ret_ena && ~empty.
  - Clears vld at ret_ptr and advances ret_ptr.
  - oitf_ret_ena while empty is ignored.
- Allocate and retire may fire in the same cycle. In that case occupancy is unchanged, both pointers advance, and full/empty flags do not toggle.
- oitf_ret_ptr, oitf_ret_rdidx and oitf_ret_rdwen always reflect the ret_ptr entry, combinationally. They are undefined-but-stable (stored value) when empty.
- Hazard match is combinational, zero latency, evaluated over all entries with vld=1:
  - rs1 match: rs1en && rdwen_e && (rdidx_e == rs1idx) && (rs1idx != 0).
  - rs2 and rd matches follow the same form; rd uses disp_oitf_rdwen and rdidx.
  - Each output is the OR over all entries.
  - x0 never matches.
  - A same-cycle allocating instruction is not checked against itself.
- Reset (rst_n low, asynchronous):
  - All vld = 0, both pointers and flags = 0.
  - Outputs: oitf_empty=1, oitf_full=0, disp_oitf_ready=1, disp_oitf_ptr=0, oitf_ret_ptr=0, all match outputs 0.
  - oitf_ret_rdidx=0 and oitf_ret_rdwen=0, because entry payload also resets to 0.
  - Reset mid-operation discards all entries with no retire indication.
- No other state; no combinational path from oitf_ret_ena to disp_oitf_ready (unless the optional feature is compiled in).

Optional Feature:
- OITF_RET_BYPASS_EN
- Defined:
  - Any entry retiring this cycle (oitf_ret_ena && ~empty, entry at ret_ptr) is masked out of the three match outputs in the same cycle.
  - disp_oitf_ready = ~full || oitf_ret_ena, so a full OITF accepts an allocation in the retire cycle.
  - This saves one cycle of dispatch stall and adds an oitf_ret_ena -> dispatch combinational path.
- Undefined: the retiring entry still matches in its retire cycle, and ready depends on registered state only.

Test Plan:
- Reset, then idle → empty=1, full=0, ready=1, ptr=0, all matches 0.
- Allocate rd=x5 rdwen=1, then present rs1idx=5 rs1en=1 → match_disprs1=1; present rs2idx=5 rs2en=0 → match_disprs2=0.
- Allocate rd=x0 rdwen=1, present rs1idx=0 rs1en=1 → match_disprs1=0.
- DEPTH=2: allocate twice → full=1, ready=0; third ena ignored, ptr stays 0 with flag 1. Retire → ret_rdidx equals the first rd, full=0.
- DEPTH=2, full: assert ret_ena and disp_oitf_ena together.
  - Without the macro: only the retire happens, occupancy becomes 1.
  - With OITF_RET_BYPASS_EN: both happen and full stays 1.
- Repeated alloc/retire pairs across 5 wraps (use DEPTH=3 as well) → ptrs cycle 0,1,2,0…, empty/full never spuriously assert; assert rst_n low with 2 entries valid → empty=1 immediately.
